// File: rtl/iobuf_seq_pkg.sv
// Shared types and constants for the IO buffer direction sequencer.
// State encoding, channel indices and default dead-time.
package iobuf_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OFF,
        DEAD1,
        SET,
        DEAD2,
        ON,
        DONE
    } state_t;

    localparam int CH_MOSI  = 0;
    localparam int CH_CLOCK = 1;
    localparam int CH_MISO  = 2;
    localparam int CH_CS    = 3;
    localparam int CH_AUX   = 4;

    localparam int NCH_DEF      = 5;
    localparam int DEAD_CYC_DEF = 4;

endpackage

// File: rtl/iobuf_seq_timer.sv
// Dead-time down-counter: load, count while enabled, saturate at zero.
// The zero flag is what the sequencer waits on.
module iobuf_seq_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/iobuf_dir_seq.sv
// Per-channel IO buffer direction sequencer with dead-time around changes.
// Define IOBUF_SEQ_OD_EN to enable the open-drain (bufod) control path.
module iobuf_dir_seq
    import iobuf_seq_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_ch,
    input  logic           req_dir,
    input  logic           req_od,
    input  logic           req_oe,
    output logic [NCH-1:0] bufdir,
    output logic [NCH-1:0] bufod,
    output logic [NCH-1:0] buftoe,
    output logic           done,
    output logic           err,
    output logic           busy
);

    localparam int CW = $clog2(DEAD_CYC + 1);
    localparam logic [CW-1:0] LOAD_V = CW'(DEAD_CYC - 1);

    state_t state, state_nx;

    logic [2:0] lat_ch;
    logic       lat_dir, lat_od, lat_oe;
    logic       accept, ch_bad, same;
    logic       cur_dir, cur_od, cur_toe;
    logic       tmr_load, tmr_en, tmr_zero;
    logic       clr_toe, set_cfg, set_toe;
    logic       done_nx, err_nx;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign ch_bad    = int'(lat_ch) >= NCH;
    assign tmr_en    = (state == DEAD1) || (state == DEAD2);

    always_comb begin
        cur_dir = 1'b0;
        cur_od  = 1'b0;
        cur_toe = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(lat_ch) == i) begin
                cur_dir = bufdir[i];
                cur_od  = bufod[i];
                cur_toe = buftoe[i];
            end
        end
    end

    // buftoe holds oe gated by dir, so compare against that form
    assign same = (lat_dir == cur_dir) && (lat_od == cur_od)
               && ((lat_oe & lat_dir) == cur_toe);

    iobuf_seq_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (LOAD_V),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        clr_toe  = 1'b0;
        set_cfg  = 1'b0;
        set_toe  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE:  if (accept) state_nx = OFF;
            OFF: begin
                if (ch_bad) begin
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else if (same) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    clr_toe  = 1'b1;
                    tmr_load = 1'b1;
                    state_nx = DEAD1;
                end
            end
            DEAD1: if (tmr_zero) state_nx = SET;
            SET: begin
                set_cfg  = 1'b1;
                tmr_load = 1'b1;
                state_nx = DEAD2;
            end
            DEAD2: if (tmr_zero) state_nx = ON;
            ON: begin
                set_toe  = 1'b1;
                done_nx  = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_ch  <= '0;
            lat_dir <= 1'b0;
            lat_oe  <= 1'b0;
            bufdir  <= '0;
            buftoe  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= done_nx;
            err  <= err_nx;
            if (accept) begin
                lat_ch  <= req_ch;
                lat_dir <= req_dir;
                lat_oe  <= req_oe;
            end
            for (int i = 0; i < NCH; i++) begin
                if (int'(lat_ch) == i) begin
                    if (clr_toe) buftoe[i] <= 1'b0;
                    if (set_cfg) bufdir[i] <= lat_dir;
                    if (set_toe) buftoe[i] <= lat_oe & lat_dir;
                end
            end
        end
    end

`ifdef IOBUF_SEQ_OD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_od <= 1'b0;
            bufod  <= '0;
        end else begin
            if (accept) lat_od <= req_od;
            for (int i = 0; i < NCH; i++) begin
                if (int'(lat_ch) == i && set_cfg) bufod[i] <= lat_od;
            end
        end
    end
`else
    logic unused_od;
    assign unused_od = req_od;
    assign lat_od    = 1'b0;
    assign bufod     = '0;
`endif

endmodule

// File: tb/tb_iobuf_dir_seq.sv
// Scoreboard bench for iobuf_dir_seq: directed requests, timed output checks.
// Completion/rejection pulses are matched by a separate monitor process.
module tb_iobuf_dir_seq;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int FULL = 3 + 2 * D;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_ch;
    logic         req_dir;
    logic         req_od;
    logic         req_oe;
    logic [N-1:0] bufdir;
    logic [N-1:0] bufod;
    logic [N-1:0] buftoe;
    logic         done;
    logic         err;
    logic         busy;

    iobuf_dir_seq #(.NCH(N), .DEAD_CYC(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ch    (req_ch),
        .req_dir   (req_dir),
        .req_od    (req_od),
        .req_oe    (req_oe),
        .bufdir    (bufdir),
        .bufod     (bufod),
        .buftoe    (buftoe),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           is_err;
        int           a_cyc;
        int           lat;
        logic [N-1:0] dir;
        logic [N-1:0] od;
        logic [N-1:0] toe;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [N-1:0] mdir, mod, mtoe;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expected response
    always @(negedge clk) begin
        if (rst === 1'b0 && (done === 1'b1 || err === 1'b1)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_kind", {30'd0, done, err},
                    mon_e.is_err ? 32'd1 : 32'd2);
                chk("sb_latency", cyc - mon_e.a_cyc, mon_e.lat);
                chk("sb_bufdir", bufdir, mon_e.dir);
                chk("sb_bufod", bufod, mon_e.od);
                chk("sb_buftoe", buftoe, mon_e.toe);
            end
        end
    end

    task automatic req(input int ch, input logic dir, input logic od,
                       input logic oe, input int abort_k);
        logic [N-1:0] odir, ood, otoe, ndir, nod, ntoe;
        logic [N-1:0] edir, eod, etoe, msk;
        logic [2:0]   c;
        logic         odeff;
        bit           is_err, full;
        int           lat;
`ifdef IOBUF_SEQ_OD_EN
        odeff = od;
`else
        odeff = 1'b0;
`endif
        c = ch[2:0];
        odir = mdir; ood = mod; otoe = mtoe;
        ndir = odir; nod = ood; ntoe = otoe;
        msk = '0;
        is_err = (ch >= N);
        full = 1'b0;
        if (!is_err) begin
            msk[c] = 1'b1;
            full = !(odir[c] == dir && ood[c] == odeff
                     && otoe[c] == (oe & dir));
            if (full) begin
                ndir[c] = dir;
                nod[c]  = odeff;
                ntoe[c] = oe & dir;
            end
        end
        lat = full ? FULL : 1;

        @(negedge clk);
        chk("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_ch    = c;
        req_dir   = dir;
        req_od    = od;
        req_oe    = oe;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (abort_k == 0)
            sbq.push_back('{is_err, cyc, lat, ndir, nod, ntoe});

        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk);
            if (k == abort_k) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_bufdir", bufdir, 32'd0);
                chk("rst_bufod", bufod, 32'd0);
                chk("rst_buftoe", buftoe, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_ready", {31'd0, req_ready}, 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_done", {30'd0, done, err}, 32'd0);
                end
                rst = 1'b0;
                mdir = '0; mod = '0; mtoe = '0;
                return;
            end
            #1;
            // Requests offered while busy must be ignored
            if (full && k >= 2 && k <= 4) begin
                req_valid = 1'b1;
                req_ch    = 3'd1;
                req_dir   = ~dir;
                req_oe    = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            edir = (full && k >= 2 + D) ? ndir : odir;
            eod  = (full && k >= 2 + D) ? nod  : ood;
            if (!full)          etoe = otoe;
            else if (k >= FULL) etoe = ntoe;
            else                etoe = otoe & ~msk;
            chk("bufdir", bufdir, edir);
            chk("bufod", bufod, eod);
            chk("buftoe", buftoe, etoe);
            chk("busy", {31'd0, busy}, {31'd0, k <= lat});
            chk("ready", {31'd0, req_ready}, {31'd0, k > lat});
            chk("done", {31'd0, done}, {31'd0, !is_err && k == lat});
            chk("err", {31'd0, err}, {31'd0, is_err && k == lat});
        end
        mdir = ndir; mod = nod; mtoe = ntoe;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_ch = '0; req_dir = 1'b0; req_od = 1'b0; req_oe = 1'b0;
        mdir = '0; mod = '0; mtoe = '0;
        repeat (2) @(negedge clk);
        chk("inrst_ready", {31'd0, req_ready}, 32'd0);
        chk("inrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_bufdir", bufdir, 32'd0);
        chk("reset_bufod", bufod, 32'd0);
        chk("reset_buftoe", buftoe, 32'd0);
        chk("reset_pulses", {30'd0, done, err}, 32'd0);

        req(0, 1'b1, 1'b0, 1'b1, 0);
        req(3, 1'b1, 1'b0, 1'b0, 0);
        req(0, 1'b0, 1'b0, 1'b1, 0);
        req(5, 1'b1, 1'b1, 1'b1, 0);
        req(3, 1'b1, 1'b0, 1'b0, 0);
        req(3, 1'b1, 1'b0, 1'b1, 0);
        req(2, 1'b1, 1'b1, 1'b1, 0);
        req(2, 1'b1, 1'b0, 1'b1, 0);
        req(7, 1'b0, 1'b0, 1'b0, 0);
        req(4, 1'b1, 1'b0, 1'b1, 7);
        req(1, 1'b1, 1'b0, 1'b1, 0);
        req(1, 1'b1, 1'b0, 1'b1, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
